// File: rtl/cpu_control_if.sv
// rtl/cpu_control_if.sv - CPU to register-file memory bus
// Carries the state code, decoded addresses and result to memory, and operands plus handshakes back.
interface cpu_control_if;
    logic [2:0]  stateCPU;
    logic [2:0]  opcode;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic [3:0]  addr3;
    logic [15:0] valorGuardarRAM;
    logic [15:0] v1RAM;
    logic [15:0] v2RAM;
    logic        read;
    logic        stored;

    modport master (
        output stateCPU, opcode, addr1, addr2, addr3, valorGuardarRAM,
        input  v1RAM, v2RAM, read, stored
    );

    modport slave (
        input  stateCPU, opcode, addr1, addr2, addr3, valorGuardarRAM,
        output v1RAM, v2RAM, read, stored
    );
endinterface

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - mini-CPU control/execute stage
// Runs the fetch-decode-read-calc-show-store cycle, one instruction per send press.
module cpu_control #(
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               power,
    input  logic               send,
    input  logic [17:0]        instr,
    cpu_control_if.master      mem,
    output logic [15:0]        show_value,
    output logic               show_valid,
    output logic               err
);
    typedef enum logic [2:0] {
        S_OFF    = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_READ   = 3'b011,
        S_CALC   = 3'b100,
        S_SHOW   = 3'b101,
        S_STORE  = 3'b110
    } state_t;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

    state_t          state;
    logic            send_q;
    logic [6:0]      imm7_q;
    logic [CW-1:0]   tcnt;
    logic            accept;
    logic [15:0]     imm;
    logic [15:0]     result;
    logic [3:0]      f1;
    logic [3:0]      f2;
    logic [3:0]      f3;

    assign accept       = send & ~send_q;
    assign mem.stateCPU = state;
    assign f1           = instr[14:11];
    assign f2           = instr[10:7];
    assign f3           = instr[6:3];

    always_comb begin
        imm    = {{9{imm7_q[6]}}, imm7_q};
        result = 16'h0000;
        case (mem.opcode)
            OP_LOAD:    result = imm;
            OP_ADD:     result = mem.v1RAM + mem.v2RAM;
            OP_ADDI:    result = mem.v1RAM + imm;
            OP_SUB:     result = mem.v1RAM - mem.v2RAM;
            OP_SUBI:    result = mem.v1RAM - imm;
            OP_MUL:     result = mem.v1RAM * imm;
            OP_CLEAR:   result = 16'h0000;
            OP_DISPLAY: result = mem.v1RAM;
            default:    result = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_OFF;
            send_q              <= 1'b0;
            imm7_q              <= '0;
            tcnt                <= '0;
            mem.opcode          <= '0;
            mem.addr1           <= '0;
            mem.addr2           <= '0;
            mem.addr3           <= '0;
            mem.valorGuardarRAM <= '0;
            show_value          <= '0;
            show_valid          <= 1'b0;
            err                 <= 1'b0;
        end else begin
            send_q     <= send;
            show_valid <= 1'b0;
            if (!power) begin
                state               <= S_OFF;
                imm7_q              <= '0;
                tcnt                <= '0;
                mem.opcode          <= '0;
                mem.addr1           <= '0;
                mem.addr2           <= '0;
                mem.addr3           <= '0;
                mem.valorGuardarRAM <= '0;
                show_value          <= '0;
                err                 <= 1'b0;
            end else begin
                case (state)
                    S_OFF: state <= S_FETCH;
                    S_FETCH: begin
                        if (accept) begin
                            mem.opcode <= instr[17:15];
                            imm7_q     <= instr[6:0];
                            err        <= 1'b0;
                            state      <= S_DECODE;
                            // unused address fields for an opcode are forced to 0
                            case (instr[17:15])
                                OP_LOAD, OP_DISPLAY: begin
                                    mem.addr1 <= f1;  mem.addr2 <= '0;  mem.addr3 <= '0;
                                end
                                OP_ADD, OP_SUB: begin
                                    mem.addr1 <= f2;  mem.addr2 <= f3;  mem.addr3 <= f1;
                                end
                                OP_ADDI, OP_SUBI, OP_MUL: begin
                                    mem.addr1 <= f2;  mem.addr2 <= f1;  mem.addr3 <= '0;
                                end
                                default: begin
                                    mem.addr1 <= '0;  mem.addr2 <= '0;  mem.addr3 <= '0;
                                end
                            endcase
                        end
                    end
                    S_DECODE: begin
                        tcnt  <= '0;
                        state <= S_READ;
                    end
                    S_READ: begin
                        if (mem.read) begin
                            state <= S_CALC;
                        end else if (tcnt == TLIM) begin
                            err   <= 1'b1;
                            state <= S_FETCH;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_CALC: begin
                        mem.valorGuardarRAM <= result;
                        show_value          <= result;
                        show_valid          <= 1'b1;
                        state               <= S_SHOW;
                    end
                    S_SHOW: begin
                        tcnt  <= '0;
                        state <= (mem.opcode == OP_DISPLAY) ? S_FETCH : S_STORE;
                    end
                    S_STORE: begin
                        if (mem.stored) begin
                            state <= S_FETCH;
                        end else if (tcnt == TLIM) begin
                            err   <= 1'b1;
                            state <= S_FETCH;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: state <= S_OFF;
                endcase
            end
        end
    end
endmodule

// File: doc/cpu_control.md
# cpu_control

Control and execute stage of the mini-CPU, sitting directly upstream of the register-file memory block. It runs the instruction cycle OFF → FETCH → DECODE → READ → CALC → SHOW → STORE and accepts one 18-bit instruction per `send` press. It drives `stateCPU`, `opcode` and the decoded `addr1`/`addr2`/`addr3` into memory, consumes `v1RAM`/`v2RAM` and the `read`/`stored` handshakes, computes the result, and returns it as `valorGuardarRAM` plus a display value.

## Interface
- TIMEOUT, 8: cycles allowed in READ or STORE for the handshake before abort.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- power  in  1  level; 0 forces OFF.
- send  in  1  synchronous level; a 0→1 transition requests instruction acceptance.
- instr  in  18  instruction: [17:15] opcode, [14:11] F1, [10:7] F2, [6:3] F3, [6:0] imm7 (overlaps F3).
- v1RAM, v2RAM  in  16 each  operands from memory.
- read  in  1  memory read-done flag.
- stored  in  1  memory store-done flag.
- stateCPU  out  3  state code: OFF=000, FETCH=001, DECODE=010, READ=011, CALC=100, SHOW=101, STORE=110.
- opcode  out  3  latched opcode: LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
- addr1, addr2, addr3  out  4 each  decoded register addresses.
- valorGuardarRAM  out  16  result to be stored.
- show_value  out  16  last shown result.
- show_valid  out  1  one-cycle pulse in SHOW.
- err  out  1  sticky handshake-timeout flag.

## Operation
- Reset: state OFF. Every output is 0.
- The send edge detector is one register, `send_q`. Accept condition: `send & ~send_q`. Holding `send` high never retriggers.
- Decoding occurs when the instruction is latched. Address fields not listed for an opcode are driven 0:
  - LOAD: addr1=F1.
  - ADD, SUB: addr3=F1 (destination), addr1=F2, addr2=F3.
  - ADDI, SUBI, MUL: addr2=F1 (destination), addr1=F2.
  - DISPLAY: addr1=F1.
  - CLEAR: no addresses.
- imm = imm7 sign-extended to 16 bits, giving a range of -64..63.
- FSM transitions:
  - OFF: if power=1, go to FETCH.
  - FETCH: on accept, latch opcode and addresses, clear err, go to DECODE.
  - DECODE: one cycle, then READ.
  - READ: stay until read=1, then CALC. Memory samples during the first READ cycle and raises `read` one cycle later, so READ takes 2 cycles minimum.
  - CALC: register the result, then SHOW.
  - SHOW: show_value <= result and pulse show_valid. DISPLAY goes to FETCH; every other opcode goes to STORE.
  - STORE: stay until stored=1, then FETCH. Memory clears `stored` in FETCH, so STORE takes 2 cycles minimum.
- Result arithmetic, all modulo 2^16 with no saturation and no flags:
  - LOAD = imm
  - ADD = v1+v2
  - ADDI = v1+imm
  - SUB = v1−v2
  - SUBI = v1−imm
  - MUL = low 16 bits of v1×imm (signed imm)
  - CLEAR = 0
  - DISPLAY = v1
- Timeout: a counter clears on entry to READ or STORE and increments each cycle the handshake is low. When it reaches TIMEOUT, the FSM sets err=1 and goes to FETCH without storing.
- Power drop: power=0 in any state moves to OFF on the next edge and resets all outputs to 0, including show_value and err. Power restored means OFF → FETCH; any in-flight instruction is lost.
- Reset mid-operation: asynchronous return to OFF, outputs 0 immediately.

## Timing
- Each state lasts one cycle except the handshake waits in READ and STORE.
- Latency for an ADD, from the accept edge to the return to FETCH, is 7 cycles: DECODE 1, READ 2, CALC 1, SHOW 1, STORE 2. DISPLAY takes 5 cycles.
- opcode and addr1..3 are stable from DECODE through STORE. They change only at the accept edge or in OFF.
- valorGuardarRAM updates at the CALC→SHOW edge and holds through STORE.
- An accept is ignored outside FETCH, but `send_q` still tracks `send`.

## Test plan
- LOAD: instr = {000, F1=3, imm7=5} → in STORE, stateCPU=110, addr1=3, valorGuardarRAM=0x0005; back in FETCH after stored=1.
- ADD wrap: {001, F1=4, F2=1, F3=2} with v1=0x0007, v2=0xFFFF → addr3=4, addr1=1, addr2=2, result 0x0006, show_valid high for exactly 1 cycle.
- SUBI/MUL immediates: SUBI v1=0, imm7=0x7F (−1) → result 0x0001. MUL v1=0x4000, imm=4 → result 0x0000.
- DISPLAY: {111, F1=9}, v1=0x1234 → addr1=9, show_value=0x1234, SHOW→FETCH with no STORE state.
- Timeout: hold read=0 in READ → after 8 cycles err=1 and state is FETCH. The next accepted instruction clears err.
- Power and send: power=0 during CALC → OFF next edge with all outputs 0; power=1 → FETCH. Holding send high for 20 cycles executes exactly one instruction.
